// File: rtl/cordic_pkg.sv
// Shared constants and tag type for the CORDIC angle scheduler.
// Angles are Q.15 radians; tags carry a channel id wide enough for eight requesters.
package cordic_pkg;

   localparam int HALF_PI_Q = 51472;
   localparam int TWO_PI_Q  = 205887;
   localparam int ANGLE_W   = 18;
   localparam int THETA_W   = 17;
   localparam int XY_W      = 16;
   localparam int TAG_CH_W  = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_CH_W-1:0] ch;
   } tag_t;

endpackage

// File: rtl/cordic_angle_sched_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from the pointer, zero latency.
// The pointer moves to granted+1 on every grant and holds when nothing requests.
module rr_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   gnt_idx,
   output logic              gnt_vld
);

   logic [CH_W-1:0] ptr;

   function automatic logic [CH_W-1:0] rr_pos(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) s -= NUM_CH;
      return CH_W'(s);
   endfunction

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!gnt_vld && req[rr_pos(ptr, i)]) begin
            gnt_vld              = 1'b1;
            gnt_idx              = rr_pos(ptr, i);
            gnt[rr_pos(ptr, i)]  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr <= '0;
      end else if (gnt_vld) begin
         ptr <= (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/cordic_angle_sched.sv
// Shares one CORDIC angle engine among NUM_CH channels; accept->result is CORDIC_LAT+2 edges.
// Per-channel one-deep slots give req_ready backpressure; results have no backpressure.
module cordic_angle_sched #(
   parameter int NUM_CH     = 4,
   parameter int CH_W       = 2,
   parameter int CORDIC_LAT = 9,
   parameter int HALF_PI_Q  = cordic_pkg::HALF_PI_Q,
   parameter int TWO_PI_Q   = cordic_pkg::TWO_PI_Q
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_CH-1:0]    req_valid,
   output logic [NUM_CH-1:0]    req_ready,
   input  logic [NUM_CH*16-1:0] req_cx,
   input  logic [NUM_CH*16-1:0] req_cy,
   output logic [15:0]          eng_cx,
   output logic [15:0]          eng_cy,
   input  logic [16:0]          eng_theta,
   input  logic [1:0]           eng_quad,
   output logic                 res_valid,
   output logic [CH_W-1:0]      res_ch,
   output logic [17:0]          res_angle,
   output logic                 busy
);

   import cordic_pkg::*;

   logic [NUM_CH-1:0] pending;
   logic [NUM_CH-1:0] accept;
   logic [NUM_CH-1:0] gnt;
   logic [CH_W-1:0]   gnt_idx;
   logic              gnt_vld;
   logic [XY_W-1:0]   slot_cx [NUM_CH];
   logic [XY_W-1:0]   slot_cy [NUM_CH];

   // Entry 0 travels with eng_cx/eng_cy; the last entry lines up with the engine output.
   tag_t              tag_pipe [CORDIC_LAT+1];
   logic              tag_any;
   logic              unused_tag_ch;

   logic [18:0]        quad_term;
   logic signed [18:0] sum_s;
   logic signed [18:0] wrap_s;

   assign req_ready = ~pending;
   assign accept    = req_valid & ~pending;

   rr_arbiter #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (pending),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // A slot is either empty (may accept) or pending (may be granted), never both.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pending <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            slot_cx[k] <= '0;
            slot_cy[k] <= '0;
         end
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (accept[k]) begin
               pending[k] <= 1'b1;
               slot_cx[k] <= req_cx[XY_W*k +: XY_W];
               slot_cy[k] <= req_cy[XY_W*k +: XY_W];
            end else if (gnt[k]) begin
               pending[k] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eng_cx <= '0;
         eng_cy <= '0;
         for (int i = 0; i <= CORDIC_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         if (gnt_vld) begin
            eng_cx            <= slot_cx[gnt_idx];
            eng_cy            <= slot_cy[gnt_idx];
            tag_pipe[0].valid <= 1'b1;
            tag_pipe[0].ch    <= TAG_CH_W'(gnt_idx);
         end else begin
            tag_pipe[0] <= '0;
         end
         for (int i = 1; i <= CORDIC_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   // Quadrant offset plus first-quadrant theta, folded once into [0, 2pi).
   always_comb begin
      quad_term = 19'(eng_quad) * 19'(HALF_PI_Q);
      sum_s     = $signed(quad_term) + $signed({{2{eng_theta[THETA_W-1]}}, eng_theta});
      if (sum_s[18]) begin
         wrap_s = sum_s + 19'(TWO_PI_Q);
      end else if (sum_s >= 19'(TWO_PI_Q)) begin
         wrap_s = sum_s - 19'(TWO_PI_Q);
      end else begin
         wrap_s = sum_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_valid <= 1'b0;
         res_ch    <= '0;
         res_angle <= '0;
      end else begin
         res_valid <= tag_pipe[CORDIC_LAT].valid;
         if (tag_pipe[CORDIC_LAT].valid) begin
            res_ch    <= CH_W'(tag_pipe[CORDIC_LAT].ch);
            res_angle <= wrap_s[ANGLE_W-1:0];
         end
      end
   end

   always_comb begin
      tag_any = 1'b0;
      for (int i = 0; i <= CORDIC_LAT; i++) begin
         tag_any = tag_any | tag_pipe[i].valid;
      end
   end

   assign busy          = (|pending) | tag_any | res_valid;
   assign unused_tag_ch = ^tag_pipe[CORDIC_LAT].ch;

endmodule

// File: tb/tb_cordic_angle_sched.sv
// Scoreboard bench for cordic_angle_sched with an in-bench engine model (geometric or raw mode).
// Expected angles come from atan2 or from direct modular arithmetic on the forced engine outputs.
module tb_cordic_angle_sched;

   localparam int  NCH      = 4;
   localparam int  CHW      = 2;
   localparam int  LAT      = 9;
   localparam int  BASE_LAT = LAT + 2;
   localparam int  TWO_PI   = 205887;
   localparam real PI       = 3.14159265358979;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic [NCH-1:0]     req_valid;
   logic [NCH-1:0]     req_ready;
   logic [NCH*16-1:0]  req_cx;
   logic [NCH*16-1:0]  req_cy;
   logic [15:0]        eng_cx;
   logic [15:0]        eng_cy;
   logic [16:0]        eng_theta;
   logic [1:0]         eng_quad;
   logic               res_valid;
   logic [CHW-1:0]     res_ch;
   logic [17:0]        res_angle;
   logic               busy;

   typedef struct {
      int angle;
      int tol;
      int acc;
      bit solo;
   } exp_t;

   exp_t chq [NCH][$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   bit   raw_mode = 1'b0;
   bit   rec_en   = 1'b0;
   int   fair_acc = 0;
   int   seq_ch[$];
   int   seq_cyc[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   cordic_angle_sched dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_cx    (req_cx),
      .req_cy    (req_cy),
      .eng_cx    (eng_cx),
      .eng_cy    (eng_cy),
      .eng_theta (eng_theta),
      .eng_quad  (eng_quad),
      .res_valid (res_valid),
      .res_ch    (res_ch),
      .res_angle (res_angle),
      .busy      (busy)
   );

   // Engine model: geometric split into quadrant + first-quadrant theta, or raw forced fields.
   function automatic logic [18:0] geo_split(input logic [15:0] cx, input logic [15:0] cy);
      int  x, y, q, th;
      real a;
      x = int'($signed(cx));
      y = int'($signed(cy));
      a = $atan2(real'(y), real'(x));
      if (a < 0.0) a = a + 2.0 * PI;
      q = int'($floor(a / (PI / 2.0)));
      if (q > 3) q = 3;
      if (q < 0) q = 0;
      th = int'((a - real'(q) * (PI / 2.0)) * 32768.0);
      return {2'(q), 17'(th)};
   endfunction

   logic [18:0] eng_pipe [LAT];
   always @(posedge clk) begin
      eng_pipe[0] <= raw_mode ? {eng_cx[1:0], eng_cx[2], eng_cy} : geo_split(eng_cx, eng_cy);
      for (int i = 1; i < LAT; i++) eng_pipe[i] <= eng_pipe[i-1];
   end
   assign eng_quad  = eng_pipe[LAT-1][18:17];
   assign eng_theta = eng_pipe[LAT-1][16:0];

   function automatic int raw_expect(input logic [15:0] cx, input logic [15:0] cy);
      int s;
      s = int'(cx[1:0]) * 51472 + int'(cy) - (cx[2] ? 65536 : 0);
      s = s % TWO_PI;
      if (s < 0) s += TWO_PI;
      return s;
   endfunction

   function automatic int geo_expect(input logic [15:0] cx, input logic [15:0] cy);
      real a;
      int  v;
      a = $atan2(real'(int'($signed(cy))), real'(int'($signed(cx))));
      if (a < 0.0) a = a + 2.0 * PI;
      v = int'(a * 32768.0) % TWO_PI;
      return v;
   endfunction

   function automatic int outstanding();
      int n = 0;
      for (int k = 0; k < NCH; k++) n += chq[k].size();
      return n;
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   task automatic set_ch(input int k, input int cx, input int cy);
      req_cx[16*k +: 16] = 16'(cx);
      req_cy[16*k +: 16] = 16'(cy);
   endtask

   task automatic push(input int k, input bit solo);
      exp_t        e;
      logic [15:0] cx, cy;
      cx     = req_cx[16*k +: 16];
      cy     = req_cy[16*k +: 16];
      e.angle = raw_mode ? raw_expect(cx, cy) : geo_expect(cx, cy);
      e.tol   = raw_mode ? 0 : 16;
      e.acc   = cyc + 1;
      e.solo  = solo;
      chq[k].push_back(e);
      if (rec_en) fair_acc++;
   endtask

   // Called at a negedge; accepts happen at the coming posedge; returns at the next negedge.
   task automatic step(input logic [NCH-1:0] v, input bit solo);
      logic [NCH-1:0] acc;
      req_valid = v;
      acc       = v & req_ready;
      for (int k = 0; k < NCH; k++) if (acc[k]) push(k, solo);
      @(negedge clk);
      for (int k = 0; k < NCH; k++)
         if (acc[k]) check($sformatf("ready_low_after_accept_ch%0d", k), int'(req_ready[k]), 0);
   endtask

   task automatic wait_idle(input int budget, input string name);
      int n = 0;
      while ((busy || outstanding() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_cmp++;
      if (n >= budget) begin
         n_bad++;
         $display("FAIL %s_timeout: busy=%0d outstanding=%0d after %0d cycles, expected idle",
                  name, busy, outstanding(), n);
      end
   endtask

   // Monitor: pops the per-channel expectation whenever a result strobe appears.
   always @(negedge clk) begin
      if (rst && res_valid) begin
         int   c, d, lat;
         exp_t e;
         c = int'(res_ch);
         if (rec_en) begin
            seq_ch.push_back(c);
            seq_cyc.push_back(cyc);
         end
         if (chq[c].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_result: ch %0d angle %0d, expected no result", c, res_angle);
         end else begin
            e = chq[c].pop_front();
            d = int'(res_angle) - e.angle;
            if (d < 0) d = -d;
            if (d > TWO_PI / 2) d = TWO_PI - d;
            n_cmp++;
            if (d > e.tol) begin
               n_bad++;
               $display("FAIL angle_ch%0d: got %0d, expected %0d +/- %0d", c, res_angle, e.angle, e.tol);
            end
            lat = cyc - e.acc;
            n_cmp++;
            if (e.solo ? (lat != BASE_LAT) : (lat < BASE_LAT || lat > BASE_LAT + NCH - 1)) begin
               n_bad++;
               $display("FAIL latency_ch%0d: got %0d, expected %0d%s", c, lat, BASE_LAT,
                        e.solo ? "" : " to 14");
            end
         end
      end
   end

   initial begin
      req_valid = '0;
      req_cx    = '0;
      req_cy    = '0;
      repeat (3) @(negedge clk);
      check("reset_req_ready", int'(req_ready), 15);
      check("reset_busy",      int'(busy), 0);
      check("reset_res_valid", int'(res_valid), 0);
      check("reset_eng_cx",    int'(eng_cx), 0);
      check("reset_res_angle", int'(res_angle), 0);
      rst = 1'b1;
      @(negedge clk);

      // Geometric engine: single requests and quadrant reconstruction.
      raw_mode = 1'b0;
      set_ch(0, 1000, 0);
      step(4'b0001, 1'b1);
      req_valid = '0;
      check("busy_after_accept", int'(busy), 1);
      wait_idle(40, "single_ch0");
      set_ch(2, 0, 1000);
      step(4'b0100, 1'b1);
      req_valid = '0;
      wait_idle(40, "quad_90");
      set_ch(2, -1000, -1000);
      step(4'b0100, 1'b1);
      req_valid = '0;
      wait_idle(40, "quad_225");

      // Forced engine outputs: wrap above 2pi and below zero.
      raw_mode = 1'b1;
      set_ch(3, 3, 32'h0000_C918);
      step(4'b1000, 1'b1);
      req_valid = '0;
      wait_idle(40, "wrap_high");
      set_ch(1, 4, -5);
      step(4'b0010, 1'b1);
      req_valid = '0;
      wait_idle(40, "wrap_low");

      // Fairness: every channel requests continuously.
      rec_en = 1'b1;
      for (int t = 0; t < 40; t++) begin
         for (int k = 0; k < NCH; k++) if (req_ready[k]) set_ch(k, $urandom, $urandom);
         step(4'b1111, 1'b0);
      end
      req_valid = '0;
      wait_idle(60, "fairness_drain");
      rec_en = 1'b0;
      check("fair_result_count", seq_ch.size(), fair_acc);
      for (int i = 1; i < seq_ch.size(); i++) begin
         check($sformatf("fair_order_%0d", i), seq_ch[i], (seq_ch[i-1] + 1) % NCH);
         check($sformatf("fair_back_to_back_%0d", i), seq_cyc[i] - seq_cyc[i-1], 1);
      end

      // Random traffic with forced engine outputs.
      for (int t = 0; t < 300; t++) begin
         for (int k = 0; k < NCH; k++) set_ch(k, $urandom, $urandom);
         step(4'($urandom_range(0, 15)), 1'b0);
      end
      req_valid = '0;
      wait_idle(80, "random_drain");

      // Reset while three requests are in flight.
      raw_mode = 1'b0;
      set_ch(0, 500, 500);
      set_ch(1, -700, 300);
      set_ch(2, 200, -900);
      step(4'b0111, 1'b0);
      req_valid = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NCH; k++) chq[k].delete();
      @(negedge clk);
      rst = 1'b1;
      check("post_reset_req_ready", int'(req_ready), 15);
      check("post_reset_busy",      int'(busy), 0);
      repeat (20) @(negedge clk);
      set_ch(1, -1000, 500);
      step(4'b0010, 1'b1);
      req_valid = '0;
      wait_idle(40, "post_reset_ch1");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
